// File: rtl/lbus2axis_rx.sv
// LBUS (CMAC RX style) segment to AXI4-Stream converter with a small FWFT beat FIFO.
// Every packet is closed with tlast, even when it is cut short by overflow or a framing error.
module lbus2axis_rx #(
    parameter int FIFO_DEPTH = 4,
    parameter int CNT_W      = 16
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [127:0]       lbus_data,
    input  logic               lbus_ena,
    input  logic               lbus_sop,
    input  logic               lbus_eop,
    input  logic               lbus_err,
    input  logic [3:0]         lbus_mty,
    output logic [127:0]       m_axis_tdata,
    output logic [15:0]        m_axis_tkeep,
    output logic               m_axis_tlast,
    output logic               m_axis_tuser,
    output logic               m_axis_tvalid,
    input  logic               m_axis_tready,
    input  logic               stat_clr,
    output logic               stat_overflow,
    output logic               stat_frame_err,
    output logic [CNT_W-1:0]   stat_drop_cnt
);
    localparam int AW = (FIFO_DEPTH > 2) ? $clog2(FIFO_DEPTH) : 1;
    localparam int CW = AW + 1;
    localparam int EW = 128 + 16 + 2;

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] PKT  = 2'd1;
    localparam logic [1:0] DROP = 2'd2;

    logic [EW-1:0]    mem [FIFO_DEPTH];
    logic [AW-1:0]    wr_ptr, rd_ptr;
    logic [CW-1:0]    count;
    logic [CW-1:0]    free;
    logic             free_ge1, free_ge2;
    logic [1:0]       state, state_next;
    logic             pkt_err;
    logic             wr_en, wr_last, trunc, wr_user;
    logic             ovf_evt, frm_evt, drop_evt;
    logic             pop;
    logic [15:0]      keep;

    // Free space deliberately ignores a same-cycle pop.
    assign free     = CW'(FIFO_DEPTH) - count;
    assign free_ge1 = (free != '0);
    assign free_ge2 = (free >= CW'(2));
    assign keep     = lbus_eop ? (16'hFFFF << lbus_mty) : 16'hFFFF;
    assign wr_user  = wr_last & (pkt_err | lbus_err | trunc);
    assign pop      = m_axis_tvalid & m_axis_tready;

    always_comb begin
        state_next = state;
        wr_en      = 1'b0;
        wr_last    = 1'b0;
        trunc      = 1'b0;
        ovf_evt    = 1'b0;
        frm_evt    = 1'b0;
        drop_evt   = 1'b0;
        if (lbus_ena) begin
            if (state == PKT) begin
                if (lbus_sop) begin
                    // Missing eop: close the open packet with this beat, lose the new one.
                    wr_en      = 1'b1;
                    wr_last    = 1'b1;
                    trunc      = 1'b1;
                    frm_evt    = 1'b1;
                    state_next = lbus_eop ? IDLE : DROP;
                end else if (lbus_eop) begin
                    wr_en      = 1'b1;
                    wr_last    = 1'b1;
                    state_next = IDLE;
                end else if (free_ge2) begin
                    wr_en      = 1'b1;
                end else begin
                    wr_en      = 1'b1;
                    wr_last    = 1'b1;
                    trunc      = 1'b1;
                    ovf_evt    = 1'b1;
                    state_next = DROP;
                end
            end else if (lbus_sop) begin
                if (!free_ge1) begin
                    ovf_evt    = 1'b1;
                    drop_evt   = 1'b1;
                    state_next = lbus_eop ? IDLE : DROP;
                end else if (lbus_eop) begin
                    wr_en      = 1'b1;
                    wr_last    = 1'b1;
                    state_next = IDLE;
                end else if (free_ge2) begin
                    wr_en      = 1'b1;
                    state_next = PKT;
                end else begin
                    wr_en      = 1'b1;
                    wr_last    = 1'b1;
                    trunc      = 1'b1;
                    ovf_evt    = 1'b1;
                    state_next = DROP;
                end
            end else if (state == DROP) begin
                drop_evt = 1'b1;
                if (lbus_eop) state_next = IDLE;
            end else begin
                frm_evt    = 1'b1;
                drop_evt   = 1'b1;
                state_next = IDLE;
            end
        end
    end

    genvar gi;
    generate
        for (gi = 0; gi < FIFO_DEPTH; gi++) begin : g_entry
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    mem[gi] <= '0;
                end else if (wr_en && (wr_ptr == AW'(gi))) begin
                    mem[gi] <= {lbus_data, keep, wr_last, wr_user};
                end
            end
        end
    endgenerate

    assign {m_axis_tdata, m_axis_tkeep, m_axis_tlast, m_axis_tuser} = mem[rd_ptr];
    assign m_axis_tvalid = (count != '0);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            count   <= '0;
            state   <= IDLE;
            pkt_err <= 1'b0;
        end else begin
            if (wr_en) wr_ptr <= wr_ptr + AW'(1);
            if (pop)   rd_ptr <= rd_ptr + AW'(1);
            count <= count + CW'(wr_en) - CW'(pop);
            state <= state_next;
            if (wr_en && wr_last)       pkt_err <= 1'b0;
            else if (wr_en && lbus_err) pkt_err <= 1'b1;
        end
    end

    // A coinciding event overrides stat_clr.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stat_overflow  <= 1'b0;
            stat_frame_err <= 1'b0;
            stat_drop_cnt  <= '0;
        end else begin
            if (ovf_evt)       stat_overflow <= 1'b1;
            else if (stat_clr) stat_overflow <= 1'b0;
            if (frm_evt)       stat_frame_err <= 1'b1;
            else if (stat_clr) stat_frame_err <= 1'b0;
            if (drop_evt) begin
                if (stat_clr)            stat_drop_cnt <= CNT_W'(1);
                else if (!(&stat_drop_cnt)) stat_drop_cnt <= stat_drop_cnt + CNT_W'(1);
            end else if (stat_clr) begin
                stat_drop_cnt <= '0;
            end
        end
    end
endmodule

// File: tb/tb_lbus2axis_rx.sv
// Directed bench for lbus2axis_rx: a queue-based packet model checked every cycle,
// plus literal expectations at key points of each scenario.
module tb_lbus2axis_rx;
    localparam int DEPTH = 4;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic [127:0] lbus_data = '0;
    logic         lbus_ena = 1'b0, lbus_sop = 1'b0, lbus_eop = 1'b0, lbus_err = 1'b0;
    logic [3:0]   lbus_mty = '0;
    logic [127:0] m_axis_tdata;
    logic [15:0]  m_axis_tkeep;
    logic         m_axis_tlast, m_axis_tuser, m_axis_tvalid;
    logic         m_axis_tready = 1'b0;
    logic         stat_clr = 1'b0;
    logic         stat_overflow, stat_frame_err;
    logic [15:0]  stat_drop_cnt;

    lbus2axis_rx #(.FIFO_DEPTH(DEPTH), .CNT_W(16)) dut (
        .clk(clk), .rst_n(rst_n),
        .lbus_data(lbus_data), .lbus_ena(lbus_ena), .lbus_sop(lbus_sop),
        .lbus_eop(lbus_eop), .lbus_err(lbus_err), .lbus_mty(lbus_mty),
        .m_axis_tdata(m_axis_tdata), .m_axis_tkeep(m_axis_tkeep),
        .m_axis_tlast(m_axis_tlast), .m_axis_tuser(m_axis_tuser),
        .m_axis_tvalid(m_axis_tvalid), .m_axis_tready(m_axis_tready),
        .stat_clr(stat_clr), .stat_overflow(stat_overflow),
        .stat_frame_err(stat_frame_err), .stat_drop_cnt(stat_drop_cnt)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [127:0] d;
        logic [15:0]  k;
        logic         l;
        logic         u;
    } beat_t;

    beat_t       q[$];
    bit          m_inpkt, m_drop, m_perr, m_ovf, m_frm;
    int unsigned m_cnt;
    int          checks = 0;
    int          failures = 0;
    bit          cmp_en = 1'b0;

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    function automatic void push(input bit last, input bit user);
        beat_t b;
        b.d = lbus_data;
        b.k = lbus_eop ? (16'hFFFF << lbus_mty) : 16'hFFFF;
        b.l = last;
        b.u = last & user;
        q.push_back(b);
    endfunction

    function automatic void model_reset();
        q.delete();
        m_inpkt = 0; m_drop = 0; m_perr = 0; m_ovf = 0; m_frm = 0; m_cnt = 0;
    endfunction

    // Apply the packet rules for the edge that just passed, using the inputs present at it.
    function automatic void model_step();
        int  free;
        bit  ovf, frm, drp;
        free = DEPTH - q.size();
        ovf = 0; frm = 0; drp = 0;
        if (q.size() > 0 && m_axis_tready) void'(q.pop_front());
        if (lbus_ena) begin
            if (m_inpkt) begin
                if (lbus_sop) begin
                    push(1, 1); frm = 1; m_perr = 0; m_inpkt = 0; m_drop = !lbus_eop;
                end else if (lbus_eop) begin
                    push(1, m_perr | lbus_err); m_perr = 0; m_inpkt = 0;
                end else if (free >= 2) begin
                    push(0, 0); m_perr |= lbus_err;
                end else begin
                    push(1, 1); ovf = 1; m_perr = 0; m_inpkt = 0; m_drop = 1;
                end
            end else if (lbus_sop) begin
                if (free == 0) begin
                    ovf = 1; drp = 1; m_drop = !lbus_eop;
                end else if (lbus_eop) begin
                    push(1, m_perr | lbus_err); m_perr = 0; m_drop = 0;
                end else if (free >= 2) begin
                    push(0, 0); m_perr = lbus_err; m_inpkt = 1; m_drop = 0;
                end else begin
                    push(1, 1); ovf = 1; m_perr = 0; m_drop = 1;
                end
            end else if (m_drop) begin
                drp = 1;
                if (lbus_eop) m_drop = 0;
            end else begin
                frm = 1; drp = 1;
            end
        end
        if (stat_clr) begin m_ovf = 0; m_frm = 0; m_cnt = 0; end
        if (ovf) m_ovf = 1;
        if (frm) m_frm = 1;
        if (drp && m_cnt != 32'hFFFF) m_cnt++;
    endfunction

    always @(negedge clk) begin
        if (cmp_en) begin
            chk("tvalid", m_axis_tvalid, q.size() > 0);
            if (q.size() > 0) begin
                chk("tdata", m_axis_tdata, q[0].d);
                chk("tkeep", m_axis_tkeep, q[0].k);
                chk("tlast", m_axis_tlast, q[0].l);
                chk("tuser", m_axis_tuser, q[0].u);
                if (m_axis_tready)
                    $display("beat data=%h keep=%h last=%0b user=%0b",
                             m_axis_tdata, m_axis_tkeep, m_axis_tlast, m_axis_tuser);
            end
            chk("stat_overflow", stat_overflow, m_ovf);
            chk("stat_frame_err", stat_frame_err, m_frm);
            chk("stat_drop_cnt", stat_drop_cnt, m_cnt);
        end
    end

    task automatic drive(input bit ena, input bit sop, input bit eop, input bit err,
                         input logic [3:0] mty, input logic [127:0] data, input bit rdy);
        lbus_ena = ena; lbus_sop = sop; lbus_eop = eop; lbus_err = err;
        lbus_mty = mty; lbus_data = data; m_axis_tready = rdy;
        @(posedge clk);
        #1;
        model_step();
        lbus_ena = 0; stat_clr = 0;
    endtask

    task automatic idle(input bit rdy);
        drive(0, 0, 0, 0, 4'd0, '0, rdy);
    endtask

    task automatic drain();
        int n = 0;
        while (q.size() > 0 && n < 50) begin
            idle(1);
            n++;
        end
        chk("drain_timeout", q.size(), 0);
    endtask

    task automatic clear_stats();
        stat_clr = 1;
        idle(1);
        chk("clr_ovf", stat_overflow, 0);
        chk("clr_frm", stat_frame_err, 0);
        chk("clr_cnt", stat_drop_cnt, 0);
    endtask

    function automatic logic [127:0] pat(input int i);
        return {4{32'hA5000000 + 32'(i)}};
    endfunction

    initial begin
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        chk("rst_tvalid", m_axis_tvalid, 0);
        chk("rst_tdata", m_axis_tdata, 0);
        chk("rst_tkeep", m_axis_tkeep, 0);
        chk("rst_tlast_tuser", {m_axis_tlast, m_axis_tuser}, 0);
        chk("rst_stats", {stat_overflow, stat_frame_err, stat_drop_cnt}, 0);
        rst_n = 1;
        idle(1);
        cmp_en = 1;

        // 3-beat packet, mty=5 on the eop beat
        drive(1, 1, 0, 0, 4'd0, pat(1), 1);
        chk("t1_first_valid", m_axis_tvalid, 1);
        chk("t1_first_keep", m_axis_tkeep, 16'hFFFF);
        drive(1, 0, 0, 0, 4'd0, pat(2), 1);
        drive(1, 0, 1, 0, 4'd5, pat(3), 1);
        chk("t1_last_keep", m_axis_tkeep, 16'hFFE0);
        chk("t1_last_flags", {m_axis_tlast, m_axis_tuser}, 2'b10);
        drain();

        // single-beat errored packet, mty=15
        drive(1, 1, 1, 1, 4'd15, pat(4), 1);
        chk("t2_keep", m_axis_tkeep, 16'h8000);
        chk("t2_flags", {m_axis_tlast, m_axis_tuser}, 2'b11);
        drain();

        // 6-beat packet with the output stalled
        for (int i = 0; i < 6; i++)
            drive(1, i == 0, i == 5, 0, 4'd0, pat(10 + i), 0);
        chk("t3_qsize", q.size(), 4);
        chk("t3_ovf", stat_overflow, 1);
        chk("t3_drop", stat_drop_cnt, 2);
        chk("t3_head_flags", {m_axis_tvalid, m_axis_tlast}, 2'b10);
        drain();
        clear_stats();

        // stray non-sop beat while idle
        drive(1, 0, 0, 0, 4'd0, pat(20), 1);
        chk("t4_no_out", m_axis_tvalid, 0);
        chk("t4_frm", stat_frame_err, 1);
        chk("t4_drop", stat_drop_cnt, 1);
        clear_stats();
        stat_clr = 1;
        drive(1, 0, 1, 0, 4'd0, pat(21), 1);
        chk("t4_clr_vs_event", stat_drop_cnt, 1);
        clear_stats();

        // sop, mid, sop (missing eop), eop
        drive(1, 1, 0, 0, 4'd0, pat(30), 1);
        drive(1, 0, 0, 0, 4'd0, pat(31), 1);
        drive(1, 1, 0, 0, 4'd0, pat(32), 1);
        chk("t5_close_flags", {m_axis_tlast, m_axis_tuser}, 2'b11);
        chk("t5_close_data", m_axis_tdata, pat(32));
        drive(1, 0, 1, 0, 4'd3, pat(33), 1);
        chk("t5_frm", stat_frame_err, 1);
        chk("t5_drop", stat_drop_cnt, 1);
        drain();
        clear_stats();

        // 4-beat packet, err on beat 2, random tready
        for (int i = 0; i < 4; i++)
            drive(1, i == 0, i == 3, i == 1, 4'd2, pat(40 + i), 1'($urandom_range(0, 1)));
        for (int i = 0; i < 12; i++) idle(1'($urandom_range(0, 1)));
        drain();

        // reset in the middle of a packet
        drive(1, 1, 0, 0, 4'd0, pat(50), 0);
        cmp_en = 0;
        rst_n = 0;
        @(posedge clk);
        #1;
        model_reset();
        chk("t7_rst_flush", m_axis_tvalid, 0);
        rst_n = 1;
        cmp_en = 1;
        drive(1, 0, 1, 0, 4'd0, pat(51), 1);
        chk("t7_frm", stat_frame_err, 1);
        chk("t7_drop", stat_drop_cnt, 1);
        chk("t7_no_out", m_axis_tvalid, 0);
        idle(1);

        cmp_en = 0;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
